// File: rtl/crossbar_rr_sched.sv
// Round-robin scheduler granting up to M of N requesters per cycle onto
// registered valid/ready output lanes, with a rotating priority pointer.
module crossbar_rr_sched #(
  parameter int DATA_W = 16,
  parameter int N      = 7,
  parameter int M      = 6,
  parameter int ID_W   = $clog2(N)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N-1:0]        ireq,
  input  logic [DATA_W*N-1:0] idata,
  output logic [N-1:0]        igrant,
  output logic [M-1:0]        oreq,
  output logic [DATA_W*M-1:0] odata,
  output logic [ID_W*M-1:0]   osrc,
  input  logic [M-1:0]        irdy
);

  if (N < M) begin : g_bad_cfg
    $fatal(1, "crossbar_rr_sched: N must be >= M");
  end

  // Modular add on the requester index; off is always below N.
  function automatic logic [ID_W-1:0] wrap_add(input logic [ID_W-1:0] base,
                                               input int unsigned     off);
    logic [ID_W:0] s;
    s = {1'b0, base} + (ID_W+1)'(off);
    if (s >= (ID_W+1)'(N)) s = s - (ID_W+1)'(N);
    return s[ID_W-1:0];
  endfunction

  logic [DATA_W-1:0] idata_a [N];
  logic [M-1:0]      lane_vld_p1;
  logic [DATA_W-1:0] lane_data_p1 [M];
  logic [ID_W-1:0]   lane_src_p1 [M];
  logic [ID_W-1:0]   ptr;

  logic [M-1:0]      lane_free;
  logic [M-1:0]      lane_alloc_p0;
  logic [ID_W-1:0]   lane_sel_p0 [M];
  logic [N-1:0]      grant_p0;
  logic              any_grant_p0;
  logic [ID_W-1:0]   last_idx_p0;

  for (genvar g = 0; g < N; g++) begin : g_unpack
    assign idata_a[g] = idata[g*DATA_W +: DATA_W];
  end

  for (genvar g = 0; g < M; g++) begin : g_pack
    assign odata[g*DATA_W +: DATA_W] = lane_data_p1[g];
    assign osrc[g*ID_W +: ID_W]      = lane_src_p1[g];
  end

  assign oreq      = lane_vld_p1;
  assign lane_free = ~lane_vld_p1 | irdy;
  assign igrant    = grant_p0;

  // Stage p0: scan requesters from ptr, each takes the lowest free lane left.
  always_comb begin
    logic [M-1:0]    avail;
    logic [ID_W-1:0] idx;
    logic            found;
    grant_p0      = '0;
    lane_alloc_p0 = '0;
    any_grant_p0  = 1'b0;
    last_idx_p0   = '0;
    avail         = lane_free;
    idx           = '0;
    found         = 1'b0;
    for (int j = 0; j < M; j++) lane_sel_p0[j] = '0;
    if (!rst) begin
      for (int k = 0; k < N; k++) begin
        idx   = wrap_add(ptr, k);
        found = 1'b0;
        if (ireq[idx]) begin
          for (int j = 0; j < M; j++) begin
            if (!found && avail[j]) begin
              found            = 1'b1;
              avail[j]         = 1'b0;
              lane_alloc_p0[j] = 1'b1;
              lane_sel_p0[j]   = idx;
            end
          end
          if (found) begin
            grant_p0[idx] = 1'b1;
            any_grant_p0  = 1'b1;
            last_idx_p0   = idx;
          end
        end
      end
    end
  end

  // Stage p1: lane registers and priority pointer.
  always_ff @(posedge clk) begin
    if (rst) begin
      lane_vld_p1 <= '0;
      ptr         <= '0;
      for (int j = 0; j < M; j++) begin
        lane_data_p1[j] <= '0;
        lane_src_p1[j]  <= '0;
      end
    end else begin
      for (int j = 0; j < M; j++) begin
        if (lane_alloc_p0[j]) begin
          lane_vld_p1[j]  <= 1'b1;
          lane_data_p1[j] <= idata_a[lane_sel_p0[j]];
          lane_src_p1[j]  <= lane_sel_p0[j];
        end else if (lane_free[j]) begin
          lane_vld_p1[j]  <= 1'b0;
        end
      end
      if (any_grant_p0) ptr <= wrap_add(last_idx_p0, 1);
    end
  end

endmodule
